card_regfile_pro: RTL and testbench

//  Parametrised card-state register file for the Memory Game: DEPTH entries of {colour, state}.

---
 rtl/card_pkg.sv | 21 ++
 rtl/card_compare.sv | 68 ++++++
 rtl/card_regfile_pro.sv | 131 +++++++++++++
 tb/tb_card_regfile_pro.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared constants and state types for the Memory Game card register file.
package card_pkg;

   localparam int unsigned DEFAULT_COLOR_W = 12;
   localparam int unsigned ST_LSB          = 0;
   localparam int unsigned ST_MSB          = 1;
   localparam int unsigned COL_LSB         = 2;

   localparam logic [1:0] ST_INACTIVE = 2'b00;
   localparam logic [1:0] ST_FACEUP   = 2'b01;
   localparam logic [1:0] ST_FACEDOWN = 2'b10;

   typedef enum logic [1:0] {CMP_IDLE, CMP_LOAD, CMP_RESULT} cmp_state_t;
   typedef enum logic       {CLR_IDLE, CLR_SWEEP}            clr_state_t;

   // Only the three defined card states may be written through the state port.
   function automatic logic st_valid(input logic [1:0] st);
      return (st == ST_INACTIVE) || (st == ST_FACEUP) || (st == ST_FACEDOWN);
   endfunction

endpackage

// File: rtl/card_compare.sv
// Pair-compare engine: latches two slot addresses, snapshots both entries, reports a match.
module card_compare
   import card_pkg::*;
#(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic              clr_busy,
   output logic [ADDR_W-1:0] rd_addr_a,
   output logic [ADDR_W-1:0] rd_addr_b,
   input  logic [DATA_W-1:0] rd_data_a,
   input  logic [DATA_W-1:0] rd_data_b,
   output logic              busy,
   output logic              done,
   output logic              match
);

   cmp_state_t        state;
   logic [DATA_W-1:0] snap_a;
   logic [DATA_W-1:0] snap_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= CMP_IDLE;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         snap_a    <= '0;
         snap_b    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         match     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            CMP_IDLE: begin
               if (start && !clr_busy) begin
                  rd_addr_a <= addr_a;
                  rd_addr_b <= addr_b;
                  busy      <= 1'b1;
                  state     <= CMP_LOAD;
               end
            end
            // Snapshot isolates the result from writes landing after this edge.
            CMP_LOAD: begin
               snap_a <= rd_data_a;
               snap_b <= rd_data_b;
               state  <= CMP_RESULT;
            end
            CMP_RESULT: begin
               match <= (snap_a[DATA_W-1:COL_LSB] == snap_b[DATA_W-1:COL_LSB]) &&
                        (snap_a[ST_MSB:ST_LSB] == ST_FACEUP) &&
                        (snap_b[ST_MSB:ST_LSB] == ST_FACEUP) &&
                        (rd_addr_a != rd_addr_b);
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= CMP_IDLE;
            end
            default: state <= CMP_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/card_regfile_pro.sv
// Card-state register file: write/state ports, bulk clear sweep, live counters and
// a pair-compare engine feeding the game-control FSM and the card renderer.
module card_regfile_pro
   import card_pkg::*;
#(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned COLOR_W = DEFAULT_COLOR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               w_enable,
   input  logic [ADDR_W-1:0]  w_address,
   input  logic [COLOR_W+1:0] w_data,
   input  logic               st_enable,
   input  logic [ADDR_W-1:0]  st_address,
   input  logic [1:0]         st_value,
   input  logic [ADDR_W-1:0]  r_address,
   output logic [COLOR_W+1:0] r_data,
   input  logic               cmp_start,
   input  logic [ADDR_W-1:0]  cmp_addr_a,
   input  logic [ADDR_W-1:0]  cmp_addr_b,
   output logic               cmp_busy,
   output logic               cmp_done,
   output logic               cmp_match,
   input  logic               clr_start,
   output logic               clr_busy,
   output logic [ADDR_W:0]    active_cnt,
   output logic [ADDR_W:0]    faceup_cnt,
   output logic               all_cleared
);

   localparam int unsigned DATA_W = COLOR_W + 2;
   localparam int unsigned CNT_W  = ADDR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   clr_state_t        clr_state;
   logic [ADDR_W-1:0] clr_idx;
   logic [ADDR_W-1:0] cmp_rd_a;
   logic [ADDR_W-1:0] cmp_rd_b;
   logic              clr_go_c;
   logic              st_apply_c;
   logic [CNT_W-1:0]  act_c;
   logic [CNT_W-1:0]  fu_c;

   assign r_data = mem[r_address];

   // A same-cycle compare request takes priority over a clear request.
   assign clr_go_c   = (clr_state == CLR_IDLE) && clr_start && !cmp_busy && !cmp_start;
   assign st_apply_c = st_enable && st_valid(st_value) &&
                       !(w_enable && (w_address == st_address));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem <= '{default: '0};
      end else if (clr_state == CLR_SWEEP) begin
         mem[clr_idx][ST_MSB:ST_LSB] <= ST_INACTIVE;
      end else begin
         if (w_enable)   mem[w_address] <= w_data;
         if (st_apply_c) mem[st_address][ST_MSB:ST_LSB] <= st_value;
      end
   end

   // Clear sweep: one slot per cycle, colours preserved.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_state <= CLR_IDLE;
         clr_idx   <= '0;
         clr_busy  <= 1'b0;
      end else begin
         case (clr_state)
            CLR_IDLE: begin
               if (clr_go_c) begin
                  clr_state <= CLR_SWEEP;
                  clr_idx   <= '0;
                  clr_busy  <= 1'b1;
               end
            end
            CLR_SWEEP: begin
               clr_idx <= clr_idx + ADDR_W'(1);
               if (clr_idx == ADDR_W'(DEPTH - 1)) begin
                  clr_state <= CLR_IDLE;
                  clr_busy  <= 1'b0;
               end
            end
            default: clr_state <= CLR_IDLE;
         endcase
      end
   end

   always_comb begin
      act_c = '0;
      fu_c  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         act_c = act_c + CNT_W'(mem[ADDR_W'(i)][ST_MSB:ST_LSB] != ST_INACTIVE);
         fu_c  = fu_c  + CNT_W'(mem[ADDR_W'(i)][ST_MSB:ST_LSB] == ST_FACEUP);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_cnt  <= '0;
         faceup_cnt  <= '0;
         all_cleared <= 1'b1;
      end else begin
         active_cnt  <= act_c;
         faceup_cnt  <= fu_c;
         all_cleared <= (act_c == '0);
      end
   end

   card_compare #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_compare (
      .clk       (clk),
      .rst       (rst),
      .start     (cmp_start),
      .addr_a    (cmp_addr_a),
      .addr_b    (cmp_addr_b),
      .clr_busy  (clr_busy),
      .rd_addr_a (cmp_rd_a),
      .rd_addr_b (cmp_rd_b),
      .rd_data_a (mem[cmp_rd_a]),
      .rd_data_b (mem[cmp_rd_b]),
      .busy      (cmp_busy),
      .done      (cmp_done),
      .match     (cmp_match)
   );

endmodule

// File: tb/tb_card_regfile_pro.sv
// Bench for card_regfile_pro: behavioural model checked every cycle plus directed literals.
module tb_card_regfile_pro;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 14;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              w_enable = 1'b0;
   logic [ADDR_W-1:0] w_address = '0;
   logic [DATA_W-1:0] w_data = '0;
   logic              st_enable = 1'b0;
   logic [ADDR_W-1:0] st_address = '0;
   logic [1:0]        st_value = '0;
   logic [ADDR_W-1:0] r_address = '0;
   logic [DATA_W-1:0] r_data;
   logic              cmp_start = 1'b0;
   logic [ADDR_W-1:0] cmp_addr_a = '0;
   logic [ADDR_W-1:0] cmp_addr_b = '0;
   logic              cmp_busy, cmp_done, cmp_match;
   logic              clr_start = 1'b0;
   logic              clr_busy;
   logic [ADDR_W:0]   active_cnt, faceup_cnt;
   logic              all_cleared;

   always #5 clk = ~clk;

   card_regfile_pro dut (
      .clk(clk), .rst(rst),
      .w_enable(w_enable), .w_address(w_address), .w_data(w_data),
      .st_enable(st_enable), .st_address(st_address), .st_value(st_value),
      .r_address(r_address), .r_data(r_data),
      .cmp_start(cmp_start), .cmp_addr_a(cmp_addr_a), .cmp_addr_b(cmp_addr_b),
      .cmp_busy(cmp_busy), .cmp_done(cmp_done), .cmp_match(cmp_match),
      .clr_start(clr_start), .clr_busy(clr_busy),
      .active_cnt(active_cnt), .faceup_cnt(faceup_cnt), .all_cleared(all_cleared)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: array contents plus countdown timers for the compare and sweep operations.
   logic [DATA_W-1:0] m_mem [DEPTH];
   int   m_act, m_fu;
   bit   m_allc, m_cbusy, m_done, m_match, m_clrbusy;
   int   cmp_phase, ca, cb, clr_left, clr_slot;
   bit   pre_idle, pre_sweep;
   logic [DATA_W-1:0] snap_a, snap_b;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         foreach (m_mem[i]) m_mem[i] = '0;
         m_act = 0; m_fu = 0; m_allc = 1;
         m_cbusy = 0; m_done = 0; m_match = 0; m_clrbusy = 0;
         cmp_phase = 0; clr_left = 0; clr_slot = 0; ca = 0; cb = 0;
      end else begin
         m_act = 0; m_fu = 0;
         foreach (m_mem[i]) begin
            if (m_mem[i][1:0] != 2'b00) m_act++;
            if (m_mem[i][1:0] == 2'b01) m_fu++;
         end
         m_allc    = (m_act == 0);
         m_done    = 0;
         pre_idle  = (cmp_phase == 0);
         pre_sweep = (clr_left > 0);
         if (cmp_phase == 2) begin
            m_match = (snap_a[13:2] == snap_b[13:2]) && (snap_a[1:0] == 2'b01) &&
                      (snap_b[1:0] == 2'b01) && (ca != cb);
            m_done = 1; m_cbusy = 0; cmp_phase = 0;
         end else if (cmp_phase == 1) begin
            snap_a = m_mem[ca]; snap_b = m_mem[cb]; cmp_phase = 2;
         end
         if (pre_sweep) begin
            m_mem[clr_slot][1:0] = 2'b00;
            clr_slot++; clr_left--;
            m_clrbusy = (clr_left > 0);
         end else begin
            if (w_enable) m_mem[w_address] = w_data;
            if (st_enable && st_value != 2'b11 && !(w_enable && w_address == st_address))
               m_mem[st_address][1:0] = st_value;
            if (pre_idle && cmp_start) begin
               ca = int'(cmp_addr_a); cb = int'(cmp_addr_b); cmp_phase = 1; m_cbusy = 1;
            end else if (pre_idle && clr_start) begin
               clr_left = DEPTH; clr_slot = 0; m_clrbusy = 1;
            end
         end
      end
   end

   initial begin : compare_proc
      forever begin
         @(posedge clk); #1;
         chk("r_data",      32'(r_data),      32'(m_mem[r_address]));
         chk("active_cnt",  32'(active_cnt),  32'(m_act));
         chk("faceup_cnt",  32'(faceup_cnt),  32'(m_fu));
         chk("all_cleared", 32'(all_cleared), 32'(m_allc));
         chk("cmp_busy",    32'(cmp_busy),    32'(m_cbusy));
         chk("cmp_done",    32'(cmp_done),    32'(m_done));
         chk("cmp_match",   32'(cmp_match),   32'(m_match));
         chk("clr_busy",    32'(clr_busy),    32'(m_clrbusy));
      end
   end

   task automatic nxt();
      @(posedge clk); #2;
   endtask

   task automatic wr(input int a, input logic [DATA_W-1:0] d);
      w_enable = 1'b1; w_address = ADDR_W'(a); w_data = d;
      nxt();
      w_enable = 1'b0;
   endtask

   task automatic st(input int a, input logic [1:0] v);
      st_enable = 1'b1; st_address = ADDR_W'(a); st_value = v;
      nxt();
      st_enable = 1'b0;
   endtask

   task automatic rd(input string name, input int a, input logic [DATA_W-1:0] exp);
      r_address = ADDR_W'(a);
      #1;
      chk(name, 32'(r_data), 32'(exp));
   endtask

   task automatic cmp(input int a, input int b);
      cmp_start = 1'b1; cmp_addr_a = ADDR_W'(a); cmp_addr_b = ADDR_W'(b);
      nxt();
      cmp_start = 1'b0;
      nxt();
      nxt();
   endtask

   initial begin : stim
      logic [11:0] col;
      int cnt;
      nxt(); nxt();
      rst = 1'b0;
      nxt();
      chk("rst_active", 32'(active_cnt), 32'd0);
      chk("rst_allclr", 32'(all_cleared), 32'd1);

      // Full write then state-only update; illegal state ignored
      wr(3, {12'hF00, 2'b01});
      st(3, 2'b10);
      rd("st_upd", 3, 14'h3C02);
      chk("faceup_lag", 32'(faceup_cnt), 32'd1);
      nxt();
      chk("active_1", 32'(active_cnt), 32'd1);
      chk("faceup_0", 32'(faceup_cnt), 32'd0);
      st(3, 2'b11);
      rd("st_ill", 3, 14'h3C02);

      // Same-address collision: full write wins; different addresses both land
      w_enable = 1'b1; w_address = 4'd5; w_data = {12'h0F0, 2'b01};
      st_enable = 1'b1; st_address = 4'd5; st_value = 2'b10;
      nxt();
      w_address = 4'd6; w_data = {12'h123, 2'b10}; st_address = 4'd3; st_value = 2'b01;
      nxt();
      w_enable = 1'b0; st_enable = 1'b0;
      rd("collide5", 5, 14'h03C1);
      rd("both6", 6, 14'h048E);
      rd("both3", 3, 14'h3C01);

      // Pair compare
      wr(2, {12'h00F, 2'b01});
      wr(7, {12'h00F, 2'b01});
      cmp(2, 7);
      chk("cmp27_done", 32'(cmp_done), 32'd1);
      chk("cmp27_match", 32'(cmp_match), 32'd1);
      nxt();
      chk("done_pulse", 32'(cmp_done), 32'd0);
      chk("match_held", 32'(cmp_match), 32'd1);
      cmp(2, 2);
      chk("cmp22_match", 32'(cmp_match), 32'd0);
      wr(7, {12'h00F, 2'b10});
      cmp(2, 7);
      chk("cmp_fd_match", 32'(cmp_match), 32'd0);

      // Write during LOAD must not disturb the snapshot
      wr(7, {12'h00F, 2'b01});
      cmp_start = 1'b1; cmp_addr_a = 4'd2; cmp_addr_b = 4'd7;
      nxt();
      cmp_start = 1'b0;
      chk("load_busy", 32'(cmp_busy), 32'd1);
      w_enable = 1'b1; w_address = 4'd7; w_data = {12'h0FF, 2'b01};
      nxt();
      w_enable = 1'b0;
      nxt();
      chk("snap_done", 32'(cmp_done), 32'd1);
      chk("snap_match", 32'(cmp_match), 32'd1);
      rd("snap_wr7", 7, 14'h03FD);

      // Compare beats clear when both requested together
      cmp_start = 1'b1; clr_start = 1'b1; cmp_addr_a = 4'd2; cmp_addr_b = 4'd5;
      nxt();
      cmp_start = 1'b0; clr_start = 1'b0;
      chk("prio_clr", 32'(clr_busy), 32'd0);
      chk("prio_cmp", 32'(cmp_busy), 32'd1);
      nxt(); nxt();
      chk("prio_match", 32'(cmp_match), 32'd0);

      // Fill all slots, then sweep with writes/compare hammered throughout
      for (int i = 0; i < DEPTH; i++) begin
         col = 12'(i * 12'h111);
         wr(i, {col, (i % 2 == 1) ? 2'b10 : 2'b01});
      end
      nxt();
      chk("full_active", 32'(active_cnt), 32'd16);
      chk("full_faceup", 32'(faceup_cnt), 32'd8);
      clr_start = 1'b1;
      nxt();
      clr_start = 1'b0;
      w_enable = 1'b1; w_address = 4'd0; w_data = 14'h3FFF;
      st_enable = 1'b1; st_address = 4'd1; st_value = 2'b01;
      cmp_start = 1'b1; cmp_addr_a = 4'd0; cmp_addr_b = 4'd2;
      cnt = 0;
      while (clr_busy && cnt < 40) begin
         cnt++;
         nxt();
      end
      w_enable = 1'b0; st_enable = 1'b0; cmp_start = 1'b0;
      chk("sweep_cycles", 32'(cnt), 32'd16);
      nxt();
      chk("sweep_allclr", 32'(all_cleared), 32'd1);
      chk("sweep_active", 32'(active_cnt), 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         col = 12'(i * 12'h111);
         rd("sweep_colour", i, {col, 2'b00});
      end

      // Reset in the middle of a sweep
      wr(4, {12'h00F, 2'b01});
      wr(9, {12'hABC, 2'b10});
      clr_start = 1'b1;
      nxt();
      clr_start = 1'b0;
      nxt();
      rst = 1'b1;
      #1;
      chk("mid_rst_active", 32'(active_cnt), 32'd0);
      chk("mid_rst_allclr", 32'(all_cleared), 32'd1);
      chk("mid_rst_clrbusy", 32'(clr_busy), 32'd0);
      chk("mid_rst_cmpbusy", 32'(cmp_busy), 32'd0);
      for (int i = 0; i < DEPTH; i++) rd("mid_rst_data", i, 14'h0000);
      nxt();
      rst = 1'b0;
      nxt(); nxt();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
